// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader: encodes RV32I descriptors and streams them as word writes into instruction memory.
module instruction_encoder_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_last,
   input  logic [3:0]  op_class,
   input  logic [2:0]  funct3,
   input  logic        alt,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  err_count,
   output logic        full
);
   localparam int PW = $clog2(DEPTH_WORDS + 1);
   localparam logic [PW-1:0] DEPTH = PW'(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic        we_q, we_d, err_q, err_d, full_q, full_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] enc;
   logic        ok, accept, sh, imm12_ok, br_ok, jal_ok;
   assign in_ready  = (state_q == LOAD) && (ptr_q < DEPTH);
   assign accept    = in_valid & in_ready;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q == LOAD) || (state_q == FLUSH);
   assign done      = state_q == DONE;
   assign err       = err_q;
   assign err_count = cnt_q;
   assign full      = full_q;
   // Sign-extension checks: the upper bits must all match the sign bit of the field.
   assign sh       = (funct3 == 3'b001) || (funct3 == 3'b101);
   assign imm12_ok = &imm[31:11] | ~|imm[31:11];
   assign br_ok    = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
   assign jal_ok   = (&imm[31:20] | ~|imm[31:20]) & ~imm[0];
   always_comb begin
      enc = 32'h0;
      ok  = 1'b0;
      case (op_class)
         4'd0: begin enc = {alt ? 7'h20 : 7'h00, rs2, rs1, funct3, rd, 7'h33}; ok = 1'b1; end
         4'd1: begin
            enc = {sh ? {1'b0, alt, 5'b0, imm[4:0]} : imm[11:0], rs1, funct3, rd, 7'h13};
            ok  = sh ? ~|imm[31:5] : imm12_ok;
         end
         4'd2: begin enc = {imm[11:0], rs1, funct3, rd, 7'h03}; ok = imm12_ok; end
         4'd3: begin enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'h23}; ok = imm12_ok; end
         4'd4: begin enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'h63}; ok = br_ok; end
         4'd5: begin enc = {imm[31:12], rd, 7'h37}; ok = ~|imm[11:0]; end
         4'd6: begin enc = {imm[31:12], rd, 7'h17}; ok = ~|imm[11:0]; end
         4'd7: begin enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F}; ok = jal_ok; end
         4'd8: begin enc = {imm[11:0], rs1, 3'b000, rd, 7'h67}; ok = imm12_ok; end
         default: begin enc = 32'h0; ok = 1'b0; end
      endcase
   end
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      full_d  = full_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            ptr_d   = '0;
            err_d   = 1'b0;
            cnt_d   = 8'h00;
            full_d  = 1'b0;
         end
         LOAD: begin
            if (accept && ok) begin
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + (32'(ptr_q) << 2);
               wdata_d = enc;
               ptr_d   = ptr_q + 1'b1;
            end else if (accept) begin
               err_d = 1'b1;
               cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'h01;
            end
            full_d  = full_q | (ptr_d == DEPTH);
            state_d = ((accept && in_last) || (ptr_d == DEPTH)) ? FLUSH : LOAD;
         end
         FLUSH:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         cnt_q   <= 8'h00;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
      end
   end
endmodule

// File: tb/tb_instruction_encoder_loader.sv
// tb_instruction_encoder_loader: directed checks of encoding, handshake, errors, full window and reset abort.
module tb_instruction_encoder_loader;
   logic        clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0;
   logic        in_valid = 1'b0, in_last = 1'b0, alt = 1'b0;
   logic [3:0]  op_class = 4'd0;
   logic [2:0]  funct3 = 3'd0;
   logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
   logic [31:0] imm = 32'h0;
   logic        rdy_a, we_a, busy_a, done_a, err_a, full_a;
   logic        rdy_b, we_b, busy_b, done_b, err_b, full_b;
   logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
   logic [7:0]  cnt_a, cnt_b;
   int checks = 0, failures = 0, writes = 0, dones = 0;
   always #5 clk = ~clk;
   instruction_encoder_loader #(.BASE_ADDR(32'h0000_1000), .DEPTH_WORDS(256)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
      .in_last(in_last), .op_class(op_class), .funct3(funct3), .alt(alt), .rd(rd), .rs1(rs1),
      .rs2(rs2), .imm(imm), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .busy(busy_a),
      .done(done_a), .err(err_a), .err_count(cnt_a), .full(full_a));
   instruction_encoder_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
      .in_last(in_last), .op_class(op_class), .funct3(funct3), .alt(alt), .rd(rd), .rs1(rs1),
      .rs2(rs2), .imm(imm), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .busy(busy_b),
      .done(done_b), .err(err_b), .err_count(cnt_b), .full(full_b));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic desc(input logic [3:0] c, input logic [2:0] f, input logic a, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im, input logic l);
      in_valid = 1'b1; op_class = c; funct3 = f; alt = a; rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = l;
   endtask
   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] w);
      chk({tag, "_we"}, 32'(we_a), 32'd1);
      chk({tag, "_addr"}, addr_a, a);
      chk({tag, "_data"}, wdata_a, w);
   endtask
   initial begin
      tick;
      tick;
      chk("rst_we", 32'(we_a), 0);
      chk("rst_addr", addr_a, 0);
      chk("rst_wdata", wdata_a, 0);
      chk("rst_flags", {26'd0, rdy_a, busy_a, done_a, err_a, full_a, we_b}, 0);
      chk("rst_cnt", 32'(cnt_a), 0);
      rst_n = 1'b1;
      tick;
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      chk("s1_busy", 32'(busy_a), 1);
      chk("s1_ready", 32'(rdy_a), 1);
      desc(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
      tick;
      wr("addi", 32'h1000, 32'h0050_0093);
      desc(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      tick;
      wr("add", 32'h1004, 32'h0020_81B3);
      desc(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      tick;
      wr("sub", 32'h1008, 32'h4020_81B3);
      desc(4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
      tick;
      wr("sw", 32'h100C, 32'h0020_A423);
      desc(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
      tick;
      wr("beq", 32'h1010, 32'h0020_8463);
      desc(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0);
      tick;
      wr("jal", 32'h1014, 32'h0100_00EF);
      desc(4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 1'b0);
      tick;
      wr("srai", 32'h1018, 32'h4031_5093);
      desc(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
      tick;
      wr("lui", 32'h101C, 32'h1234_52B7);
      in_valid = 1'b0;
      in_last = 1'b0;
      chk("s1_flush_busy", 32'(busy_a), 1);
      chk("s1_flush_ready", 32'(rdy_a), 0);
      chk("s1_flush_done", 32'(done_a), 0);
      tick;
      chk("s1_done", 32'(done_a), 1);
      chk("s1_done_busy", 32'(busy_a), 0);
      chk("s1_done_we", 32'(we_a), 0);
      chk("s1_err", 32'(err_a), 0);
      tick;
      chk("s1_done_pulse", 32'(done_a), 0);
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      desc(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0);
      tick;
      chk("odd_br_we", 32'(we_a), 0);
      chk("odd_br_err", 32'(err_a), 1);
      chk("odd_br_cnt", 32'(cnt_a), 1);
      desc(4'd9, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
      tick;
      chk("cls9_we", 32'(we_a), 0);
      chk("cls9_cnt", 32'(cnt_a), 2);
      desc(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
      tick;
      wr("s2_addi", 32'h1000, 32'h0050_0093);
      in_valid = 1'b0;
      in_last = 1'b0;
      chk("s2_no_done_yet", 32'(done_a), 0);
      tick;
      chk("s2_done", 32'(done_a), 1);
      chk("s2_err_sticky", 32'(err_a), 1);
      tick;
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      chk("s3_err_clr", 32'(err_a), 0);
      chk("s3_cnt_clr", 32'(cnt_a), 0);
      desc(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
      tick;
      chk("s3_we", 32'(we_a), 1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_we", 32'(we_a), 0);
      chk("abort_addr", addr_a, 0);
      chk("abort_wdata", wdata_a, 0);
      chk("abort_flags", {27'd0, rdy_a, busy_a, done_a, err_a, full_a}, 0);
      tick;
      rst_n = 1'b1;
      tick;
      chk("abort_idle", {30'd0, busy_a, we_a}, 0);
      start_b = 1'b1;
      tick;
      start_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         desc(4'd1, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i), i == 5);
         tick;
         if (we_b) begin
            chk("full_addr", addr_b, 32'(writes * 4));
            chk("full_data", wdata_b, (32'(writes) << 20) | (32'(writes) << 7) | 32'h13);
            writes++;
         end
         if (done_b) dones++;
         if (i == 3) chk("full_ready_low", {30'd0, rdy_b, full_b}, 32'd1);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      tick;
      if (done_b) dones++;
      chk("full_writes", 32'(writes), 4);
      chk("full_dones", 32'(dones), 1);
      chk("full_sticky", 32'(full_b), 1);
      chk("full_idle", 32'(busy_b), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
